jtkiwi_paldma: RTL and testbench

- Palette upload engine: the writer on the far end of the palette RAM that the colour mixer reads.
- On a trigger, it copies a block of palette bytes from a ROM/SDRAM slot (jtframe cs/ok handshake) into the palette RAM write port.
- Writes happen only during vertical blank, so the mixer never sees a half-updated palette mid-frame.
- Sits between the game's SDRAM slot and the X1-007 palette dual RAM, sharing port 0 with the CPU through an external mux driven by busy.

---
 rtl/jtkiwi_paldma_if.sv | 24 ++
 rtl/jtkiwi_paldma.sv | 150 +++++++++++++++
 tb/tb_jtkiwi_paldma.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtkiwi_paldma_if.sv
// Source-slot read handshake and palette RAM write port of the palette DMA.
// master = DMA engine side, slave = SDRAM slot / palette RAM side.
interface jtkiwi_paldma_if #(
  parameter int AW = 10,
  parameter int SW = 18
);
  logic          rom_cs;
  logic [SW-1:0] rom_addr;
  logic          rom_ok;
  logic [7:0]    rom_data;
  logic [AW-1:0] pal_addr;
  logic [7:0]    pal_dout;
  logic          pal_we;

  modport master (
    output rom_cs, rom_addr, pal_addr, pal_dout, pal_we,
    input  rom_ok, rom_data
  );

  modport slave (
    input  rom_cs, rom_addr, pal_addr, pal_dout, pal_we,
    output rom_ok, rom_data
  );
endinterface

// File: rtl/jtkiwi_paldma.sv
// Palette upload engine: copies LEN bytes from the ROM slot into palette RAM,
// writing only during vertical blank.
//   state  | meaning
//   IDLE   | no transfer, waiting for go
//   WAITVB | transfer open, waiting for LVBL=0
//   REQ    | rom_cs high; first cycle ignores rom_ok (stale-ok guard)
//   WR     | pal_we pulse, advance addresses and byte count
//   FIN    | done pulse; restart here if a go was queued
module jtkiwi_paldma #(
  parameter int AW  = 10,
  parameter int LEN = 1024,
  parameter int SW  = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          go,
  input  logic [SW-1:0] src_base,
  jtkiwi_paldma_if.master bus,
  output logic          busy,
  output logic          done
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_C = CW'(LEN);

  typedef enum logic [2:0] {IDLE, WAITVB, REQ, WR, FIN} state_t;

  state_t        st_q, st_d;
  logic          cs_q, cs_d;
  logic [SW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [7:0]    dout_q, dout_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pending_q, pending_d;
  logic          guard_q, guard_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_inc;
  logic          start;

  assign count_inc = count_q + 1'b1;

  always_comb begin
    st_d      = st_q;
    cs_d      = cs_q;
    raddr_d   = raddr_q;
    paddr_d   = paddr_q;
    dout_d    = dout_q;
    we_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    guard_d   = guard_q;
    count_d   = count_q;
    start     = 1'b0;

    if (busy_q && go) pending_d = 1'b1;

    case (st_q)
      IDLE: start = go;
      WAITVB: begin
        if (!LVBL) begin
          st_d    = REQ;
          cs_d    = 1'b1;
          guard_d = 1'b1;
        end
      end
      REQ: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (bus.rom_ok) begin
          dout_d = bus.rom_data;
          we_d   = 1'b1;
          cs_d   = 1'b0;
          st_d   = WR;
        end
      end
      WR: begin
        paddr_d = paddr_q + 1'b1;
        raddr_d = raddr_q + 1'b1;
        count_d = count_inc;
        if (count_inc == LEN_C) begin
          st_d   = FIN;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (LVBL) begin
          st_d = WAITVB;
        end else begin
          st_d    = REQ;
          cs_d    = 1'b1;
          guard_d = 1'b1;
        end
      end
      FIN: begin
        // a go arriving in FIN behaves like a queued one
        start = go || pending_q;
        if (!start) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase

    if (start) begin
      raddr_d   = src_base;
      paddr_d   = '0;
      count_d   = '0;
      busy_d    = 1'b1;
      pending_d = 1'b0;
      st_d      = WAITVB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cs_q      <= 1'b0;
      raddr_q   <= '0;
      paddr_q   <= '0;
      dout_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      guard_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      st_q      <= st_d;
      cs_q      <= cs_d;
      raddr_q   <= raddr_d;
      paddr_q   <= paddr_d;
      dout_q    <= dout_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      count_q   <= count_d;
    end
  end

  assign bus.rom_cs   = cs_q;
  assign bus.rom_addr = raddr_q;
  assign bus.pal_addr = paddr_q;
  assign bus.pal_dout = dout_q;
  assign bus.pal_we   = we_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_jtkiwi_paldma.sv
// Directed bench for jtkiwi_paldma: a queue of expected palette writes per
// transfer is checked against every pal_we, plus literal spot checks.
module tb_jtkiwi_paldma;
  localparam int AW  = 3;
  localparam int LEN = 8;
  localparam int SW  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          LVBL = 1'b1;
  logic          go = 1'b0;
  logic [SW-1:0] src_base = '0;
  logic          busy, done;

  jtkiwi_paldma_if #(.AW(AW), .SW(SW)) bus ();

  jtkiwi_paldma #(.AW(AW), .LEN(LEN), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .go(go), .src_base(src_base),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // source byte at address a: 0x100..0x103 hold 11,22,33,44
  function automatic logic [7:0] rom_byte(input logic [SW-1:0] a);
    return 8'((int'(a[3:0]) + 1) * 17 + int'(a[11:4]) - 16);
  endfunction

  // slot model: ok and data are registered, so data lags an address change
  logic       stale_ok = 1'b0;
  logic       ok_q = 1'b0;
  logic [7:0] data_q = 8'h00;
  always @(posedge clk) begin
    ok_q   <= bus.rom_cs;
    data_q <= rom_byte(bus.rom_addr);
  end
  assign bus.rom_ok   = stale_ok | ok_q;
  assign bus.rom_data = data_q;

  typedef struct packed {
    logic [AW-1:0] pa;
    logic [7:0]    d;
    logic          last;
  } wr_t;

  wr_t        exp_q[$];
  int         vecs = 0, miscmp = 0;
  int         n_we = 0, n_done = 0, cyc = 0;
  int         we_cyc[$];
  logic [7:0] we_dat[$];
  logic       prev_last = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push_xfer(input logic [SW-1:0] base);
    for (int i = 0; i < LEN; i++) begin
      wr_t w;
      w.pa   = AW'(i);
      w.d    = rom_byte(base + SW'(i));
      w.last = (i == LEN - 1);
      exp_q.push_back(w);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t  w;
    logic nl;
    nl = 1'b0;
    if (!rst_n) begin
      prev_last = 1'b0;
    end else begin
      if (bus.pal_we) begin
        n_we++;
        we_cyc.push_back(cyc);
        we_dat.push_back(bus.pal_dout);
        chk("we_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          vecs++;
          miscmp++;
          $display("FAIL extra_write: pal_addr=%0h data=%0h, required no write",
                   bus.pal_addr, bus.pal_dout);
        end else begin
          w = exp_q.pop_front();
          chk("pal_addr", 32'(bus.pal_addr), 32'(w.pa));
          chk("pal_dout", 32'(bus.pal_dout), 32'(w.d));
          nl = w.last;
        end
      end
      if (done || prev_last) chk("done_after_last", 32'(done), 32'(prev_last));
      if (done) begin
        n_done++;
        chk("done_busy", 32'(busy), 32'd0);
      end
      if (bus.rom_cs && bus.pal_we) chk("cs_during_we", 32'(bus.rom_cs), 32'd0);
      prev_last = nl;
    end
  end

  task automatic pulse_go(input logic [SW-1:0] b);
    @(posedge clk); #1;
    src_base = b;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (k < budget && (exp_q.size() != 0 || busy || done)) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      vecs++;
      miscmp++;
      $display("FAIL idle_timeout: got %0d writes outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int target, input int budget);
    int k = 0;
    while (k < budget && n_we < target) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      vecs++;
      miscmp++;
      $display("FAIL we_timeout: got %0d writes, required %0d", n_we, target);
    end
  endtask

  task automatic chk_gaps(input string nm);
    chk({nm, "_nwrites"}, 32'(we_cyc.size()), 32'(LEN));
    if (we_cyc.size() == LEN)
      for (int i = 1; i < LEN; i++) chk(nm, 32'(we_cyc[i] - we_cyc[i-1]), 32'd3);
  endtask

  initial begin
    int n0, t, viol;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_cs",   32'(bus.rom_cs),   32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_pal_addr", 32'(bus.pal_addr), 32'd0);
    chk("rst_pal_dout", 32'(bus.pal_dout), 32'd0);
    chk("rst_pal_we",   32'(bus.pal_we),   32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    rst_n = 1'b1;

    // basic transfer inside a long blank
    LVBL = 1'b0;
    n0 = n_done;
    we_dat.delete();
    we_cyc.delete();
    push_xfer(12'h100);
    pulse_go(12'h100);
    wait_idle(500);
    chk("basic_nwrites", 32'(we_dat.size()), 32'(LEN));
    if (we_dat.size() == LEN) begin
      chk("basic_d0", 32'(we_dat[0]), 32'h11);
      chk("basic_d1", 32'(we_dat[1]), 32'h22);
      chk("basic_d2", 32'(we_dat[2]), 32'h33);
      chk("basic_d3", 32'(we_dat[3]), 32'h44);
    end
    chk_gaps("basic_gap");
    chk("basic_rom_addr_end", 32'(bus.rom_addr), 32'h108);
    chk("basic_pal_addr_wrap", 32'(bus.pal_addr), 32'd0);
    chk("basic_done_count", 32'(n_done - n0), 32'd1);

    // blank gating
    LVBL = 1'b1;
    push_xfer(12'h140);
    pulse_go(12'h140);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rom_cs || bus.pal_we) viol++;
    end
    chk("gate_quiet", 32'(viol), 32'd0);
    chk("gate_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    LVBL = 1'b0;
    @(negedge clk);
    chk("gate_cs_same_cycle", 32'(bus.rom_cs), 32'd0);
    @(negedge clk);
    chk("gate_cs_next_cycle", 32'(bus.rom_cs), 32'd1);
    wait_idle(500);

    // pause after the 3rd write, resume next blank
    n0 = n_we;
    push_xfer(12'h100);
    pulse_go(12'h100);
    wait_we(n0 + 3, 200);
    LVBL = 1'b1;
    repeat (30) @(negedge clk);
    chk("pause_writes", 32'(n_we - n0), 32'd3);
    chk("pause_rom_addr", 32'(bus.rom_addr), 32'h103);
    chk("pause_pal_addr", 32'(bus.pal_addr), 32'd3);
    chk("pause_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("pause_busy", 32'(busy), 32'd1);
    #1 LVBL = 1'b0;
    wait_idle(500);
    chk("pause_total_writes", 32'(n_we - n0), 32'(LEN));

    // rom_ok stuck high: guard keeps 3 cycles/byte and fresh data
    stale_ok = 1'b1;
    we_cyc.delete();
    push_xfer(12'h230);
    pulse_go(12'h230);
    wait_idle(500);
    chk_gaps("stale_gap");
    stale_ok = 1'b0;

    // one queued go; the third pulse is absorbed. The restart samples
    // src_base in FIN, so it is put back to 0x200 before then.
    n0 = n_done;
    t = n_we + 2;
    push_xfer(12'h100);
    push_xfer(12'h200);
    pulse_go(12'h100);
    wait_we(t, 200);
    pulse_go(12'h200);
    repeat (3) @(posedge clk);
    pulse_go(12'h300);
    src_base = 12'h200;
    wait_idle(1000);
    chk("pend_done_count", 32'(n_done - n0), 32'd2);
    chk("pend_rom_addr_end", 32'(bus.rom_addr), 32'h208);

    // source address wraps mod 2^SW
    push_xfer(12'hFFC);
    pulse_go(12'hFFC);
    wait_idle(500);
    chk("wrap_rom_addr_end", 32'(bus.rom_addr), 32'h004);

    // reset mid-transfer
    t = n_we + 2;
    push_xfer(12'h100);
    pulse_go(12'h100);
    wait_we(t, 200);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_outputs", {bus.rom_cs, bus.pal_we, busy, done, bus.rom_addr, bus.pal_addr,
                         bus.pal_dout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = n_we;
    repeat (40) @(posedge clk);
    #1;
    chk("mrst_no_writes", 32'(n_we - n0), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    push_xfer(12'h180);
    pulse_go(12'h180);
    wait_idle(500);
    chk("mrst_restart_writes", 32'(n_we - n0), 32'(LEN));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
